serial_add: RTL and testbench
=============================

# serial_add

Bit-serial, registered two-operand adder with a start/busy/done handshake. It is the companion of the team's registered subtractor: given a difference and a subtrahend, it reconstructs the minuend (`a = diff + b`). It processes one bit per clock, LSB first, and trades latency for a single-bit datapath. It sits in the same arithmetic unit as the subtractor and shares its WIDTH convention.

## Interface
Parameters:
- WIDTH, default 2, operand and result width in bits; legal range is WIDTH >= 1.

Ports (one clock; reset is synchronous and active-low):
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request to add the current `a` and `b`.
- a, input, WIDTH, operand A; sampled only in the cycle a start is accepted.
- b, input, WIDTH, operand B; sampled only in the cycle a start is accepted.
- busy, output, 1, high while an addition is in progress (RUN state).
- done, output, 1, one-cycle pulse meaning `sum` and `cout` are valid.
- sum, output, WIDTH, result register; holds its value until the next accepted start.
- cout, output, 1, carry out of bit WIDTH-1.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, go to RUN.
  - RUN: go to DONE after WIDTH bit-steps.
  - DONE: on `start`, go to RUN (back-to-back operation); otherwise go to IDLE.
- Start acceptance:
  - A start is accepted only in IDLE or DONE.
  - On acceptance, `a` and `b` are latched into shift registers, the carry register is cleared, `sum` is cleared and the bit counter is set to 0.
  - `start` asserted in RUN is ignored. No queuing; the operands presented at that time are discarded.
- Bit-step in RUN, for bit i = counter:
  - s = a_sh[0] ^ b_sh[0] ^ c.
  - c_next = majority(a_sh[0], b_sh[0], c).
  - `a_sh` and `b_sh` shift right by one.
  - s is shifted into the MSB of `sum`, so that after WIDTH steps bit 0 of the result is in `sum[0]`.
  - After step WIDTH-1, the final carry is written to `cout`.
- Arithmetic is unsigned modulo 2^WIDTH; the carry is reported separately on `cout`. Signed callers interpret `sum` as two's complement and ignore `cout`.
- The WIDTH=1 case is legal: RUN lasts exactly one cycle.
- Reset: when `rst_n` is sampled low, the FSM returns to IDLE and busy=0, done=0, sum=0, cout=0, counter=0. This applies in any state; an operation in flight is aborted and no done pulse is produced. Reset takes priority over `start` in the same cycle.

## Timing
- Start is sampled at rising edge k.
- `busy` is high for edges k+1 through k+WIDTH, i.e. exactly WIDTH cycles.
- `done` is high for exactly one cycle, after edge k+WIDTH+1 and before edge k+WIDTH+2.
- `sum` and `cout` are final when `done` goes high and stay stable until the next accepted start.
- Latency from start to done is WIDTH+1 cycles.
- Throughput with start held high continuously is one result per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro SERIAL_ADD_SAT_EN:
  - Defined: when the final carry is 1, `sum` is forced to all ones (2^WIDTH-1) in the same cycle the carry is written. `cout` still reports 1, and `done` timing is unchanged.
  - Undefined: `sum` wraps modulo 2^WIDTH and no saturation logic is generated.

## Structure
- Shared package `serial_add_pkg`, containing:
  - the FSM state typedef (IDLE, RUN, DONE), 2-bit encoded;
  - a function that computes the counter width, clog2(WIDTH) with a minimum of 1.
- One sub-module is natural: `full_adder_bit`, a combinational 1-bit full adder (a, b, cin -> s, cout) instantiated once in the bit-step datapath.
- The FSM, counter, shift registers and carry register all stay in `serial_add`.

## Test plan
1. Reset: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, sum=0, cout=0, and no operation starts.
2. Basic, WIDTH=2: a=1, b=2, start for 1 cycle -> busy high 2 cycles, then done for 1 cycle with sum=3, cout=0.
3. Overflow, WIDTH=2: a=3, b=3 -> sum=2, cout=1. With SERIAL_ADD_SAT_EN defined -> sum=3, cout=1.
4. Start while busy, WIDTH=8: a=100, b=27, then start pulsed again in the second RUN cycle with a=1, b=1 -> a single done pulse with sum=127, cout=0; the second request is ignored.
5. Back-to-back, WIDTH=8: start held high with a=200, b=100 -> done every 9 cycles, sum=44, cout=1 each time.
6. Reset mid-operation, WIDTH=8: rst_n=0 in the 4th RUN cycle -> no done pulse, all outputs return to 0. A new start after reset gives the correct result (a=5, b=250 -> sum=255, cout=0).

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and helpers for the bit-serial adder.
//   state_t   - FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   cnt_width - bit-counter width, clog2(width) with a minimum of 1.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that indexes bits 0..width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// serial_add_if: start/busy/done handshake bundle for serial_add.
//   start - request an addition of a and b
//   a, b  - operands, sampled when a start is accepted
//   busy  - addition in progress
//   done  - one-cycle pulse, sum/cout valid
//   sum   - result register
//   cout  - carry out of the MSB
// master: requester side; slave: the adder.
interface serial_add_if #(
    parameter int unsigned WIDTH = 2
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder.
//   i_a, i_b, i_cin - addend bits and carry in
//   o_s             - sum bit
//   o_cout          - carry out (majority of the three inputs)
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_add.sv
// serial_add: bit-serial registered adder, one bit per clock, LSB first.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - serial_add_if slave modport (start/a/b in, busy/done/sum/cout out)
// Latency start->done is WIDTH+1 cycles; start held high gives one result
// every WIDTH+1 cycles. Define SERIAL_ADD_SAT_EN to saturate sum to all ones
// when the final carry is set.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    serial_add_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic               w_s;
    logic               w_c;
    logic               w_last;

    // Single bit-step of the datapath.
    full_adder_bit u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // FSM, counter, shift registers and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= 1'b0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c;
                    // New bit enters at the MSB so bit 0 lands in sum[0] last.
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout  <= w_c;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef SERIAL_ADD_SAT_EN
                        if (w_c) begin
                            r_sum <= '1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: randomized self-checking bench for serial_add at WIDTH=2
// and WIDTH=8, against an arithmetic reference model.
module tb_serial_add;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_if #(.WIDTH(2)) if2 ();
    serial_add_if #(.WIDTH(8)) if8 ();

    serial_add #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_add #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: unsigned addition, optional saturation on carry.
    task automatic model(input int w, input int unsigned a, input int unsigned b,
                         output int unsigned exp_sum, output int unsigned exp_cout);
        int unsigned t;
        int unsigned m;
        m = (32'd1 << w) - 1;
        t = (a & m) + (b & m);
        exp_cout = t >> w;
        exp_sum  = t & m;
`ifdef SERIAL_ADD_SAT_EN
        if (exp_cout != 0) exp_sum = m;
`endif
    endtask

    task automatic drive(input int w, input logic s, input int unsigned a, input int unsigned b);
        if (w == 2) begin
            if2.start = s; if2.a = 2'(a); if2.b = 2'(b);
        end else begin
            if8.start = s; if8.a = 8'(a); if8.b = 8'(b);
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 2) ? if2.busy : if8.busy;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 2) ? if2.done : if8.done;
    endfunction
    function automatic logic [31:0] get_sum(input int w);
        return (w == 2) ? 32'(if2.sum) : 32'(if8.sum);
    endfunction
    function automatic logic [31:0] get_cout(input int w);
        return (w == 2) ? 32'(if2.cout) : 32'(if8.cout);
    endfunction

    // One start pulse; optionally poke a second start at sample poke_at.
    task automatic run_op(input int w, input int unsigned a, input int unsigned b, input int poke_at);
        int unsigned es, ec;
        int busy_cnt;
        int done_cnt;
        int done_at;
        model(w, a, b, es, ec);
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, 0, 0);
        for (int j = 1; j <= w + 4; j++) begin
            @(negedge clk);
            if (get_busy(w)) busy_cnt++;
            if (get_done(w)) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = j;
                    check_eq("sum", get_sum(w), es);
                    check_eq("cout", get_cout(w), ec);
                end
            end
            if (j == poke_at) drive(w, 1'b1, 1, 1);
            else drive(w, 1'b0, 0, 0);
        end
        check_eq("busy_cycles", 32'(busy_cnt), 32'(w));
        check_eq("done_latency", 32'(done_at), 32'(w + 1));
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        check_eq("sum_hold", get_sum(w), es);
    endtask

    initial begin
        int unsigned es, ec;
        int done_cnt;
        int busy_seen;

        // Reset held with start asserted.
        rst_n = 1'b0;
        drive(2, 1'b1, 3, 3);
        drive(8, 1'b1, 200, 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy2", 32'(if2.busy), 0);
        check_eq("rst_done2", 32'(if2.done), 0);
        check_eq("rst_sum2", 32'(if2.sum), 0);
        check_eq("rst_cout2", 32'(if2.cout), 0);
        check_eq("rst_busy8", 32'(if8.busy), 0);
        check_eq("rst_sum8", 32'(if8.sum), 0);
        check_eq("rst_cout8", 32'(if8.cout), 0);
        drive(2, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle2", 32'(if2.busy), 0);
        check_eq("post_rst_idle8", 32'(if8.busy), 0);

        // Directed WIDTH=2 cases.
        run_op(2, 1, 2, 0);
        run_op(2, 3, 3, 0);

        // Start while busy is ignored.
        run_op(8, 100, 27, 2);

        // Back-to-back with start held high.
        model(8, 200, 100, es, ec);
        done_cnt = 0;
        @(negedge clk);
        drive(8, 1'b1, 200, 100);
        @(posedge clk);
        for (int j = 1; j <= 27; j++) begin
            @(negedge clk);
            if (if8.done) begin
                done_cnt++;
                check_eq("b2b_pos", 32'(j % 9), 0);
                check_eq("b2b_sum", 32'(if8.sum), es);
                check_eq("b2b_cout", 32'(if8.cout), ec);
            end
        end
        drive(8, 1'b0, 0, 0);
        check_eq("b2b_count", 32'(done_cnt), 3);
        repeat (12) @(negedge clk);

        // Reset in the 4th RUN cycle aborts the operation.
        drive(8, 1'b1, 77, 88);
        @(posedge clk);
        #1 drive(8, 1'b0, 0, 0);
        for (int j = 1; j <= 3; j++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_busy", 32'(if8.busy), 0);
        check_eq("abort_done", 32'(if8.done), 0);
        check_eq("abort_sum", 32'(if8.sum), 0);
        check_eq("abort_cout", 32'(if8.cout), 0);
        done_cnt = 0; busy_seen = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (if8.done) done_cnt++;
            if (if8.busy) busy_seen++;
        end
        check_eq("abort_no_done", 32'(done_cnt), 0);
        check_eq("abort_no_busy", 32'(busy_seen), 0);
        run_op(8, 5, 250, 0);

        // Randomized operands on both widths.
        for (int i = 0; i < 20; i++) begin
            run_op(2, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            run_op(8, $urandom_range(0, 255), $urandom_range(0, 255), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
